icache_fetch: RTL and testbench
===============================

Name: icache_fetch

Overview:
- Instruction-fetch stage with a direct-mapped instruction cache.
- Produces the IF/ID pipeline-register inputs: instruction, next PC, hit.
- Owns the PC and advances it on every hit. On a miss it stalls, refills one line from instruction memory, then replays the lookup.
- Acts as the producer side of the hit-gated IF/ID interface: a deasserted hit freezes the downstream register.

Parameters:
- LINES, 16, number of cache lines (power of 2, ≥2).
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- branch_taken  input  1  redirect request from a later stage.
- branch_target  input  32  redirect byte address (bits [1:0] ignored).
- instruction_out  output  32  cached word at current PC; valid only when hit_out=1.
- next_pc_out  output  32  current PC + 4.
- hit_out  output  1  lookup hit this cycle; downstream register captures only when 1.
- pc_out  output  32  current PC.
- mem_req  output  1  refill read request.
- mem_addr  output  32  word-aligned refill address.
- mem_ready  input  1  memory returns one word this cycle.
- mem_data  input  32  refill word.

Behaviour:
- Address split, with OFF=log2(WORDS_PER_LINE) and IDX=log2(LINES):
  - word offset = pc[OFF+1:2]
  - index = pc[OFF+IDX+1:OFF+2]
  - tag = the remaining upper bits
  - Defaults give offset [3:2], index [7:4], tag [31:8].
- Storage: valid[LINES], tag[LINES], data[LINES][WORDS_PER_LINE].
- Reset (async):
  - pc=RESET_PC, all valid=0, state=LOOKUP.
  - mem_req=0, mem_addr=0, refill counter=0, redirect_pending=0.
  - Outputs: hit_out=0, next_pc_out=RESET_PC+4, instruction_out=0.
- FSM states: LOOKUP, REFILL, INSTALL.
- LOOKUP:
  - hit_out is combinational: valid[index] && tag[index]==tag(pc).
  - instruction_out=data[index][offset] when hit, else 0.
  - On hit, next-cycle pc is pc+4, or branch_target if branch_taken (redirect wins).
  - On miss with no redirect: go to REFILL, mem_req=1, mem_addr = line base (pc with offset and byte bits zeroed), counter=0.
  - On miss with branch_taken: pc=branch_target, stay in LOOKUP, no refill.
- REFILL:
  - hit_out=0; mem_req held 1 and mem_addr held stable until mem_ready.
  - Each mem_ready beat: data[index][counter]=mem_data, counter+1, mem_addr+4.
  - After beat WORDS_PER_LINE-1 is accepted: mem_req=0, go to INSTALL.
  - Beats arriving while mem_req=0 are ignored.
- INSTALL (1 cycle):
  - valid[index]=1, tag[index]=tag(pc); hit_out=0.
  - If redirect_pending: pc=pending target, clear redirect_pending.
  - Return to LOOKUP.
- Miss latency: ≥ WORDS_PER_LINE+2 cycles from miss to hit (≥6 with defaults).
- branch_taken during REFILL/INSTALL: latch branch_target into pending (latest request wins); the refill still completes and installs the line.
- PC wrap-around: 32'hFFFF_FFFC + 4 = 0 (mod 2^32).
- Reset mid-refill: aborts immediately; mem_req drops asynchronously; the partial line is never valid.
- Conflicting line: INSTALL overwrites the tag and all data of that index.

Optional Feature:
- ICACHE_STATS_EN defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments on each LOOKUP cycle with hit_out=1.
  - miss_count increments on each LOOKUP-to-REFILL transition.
  - Counters wrap at 2^32.
- ICACHE_STATS_EN undefined: those ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package icache_pkg holds:
  - state enum {LOOKUP, REFILL, INSTALL};
  - INSTR_W=32;
  - localparam functions for OFF/IDX/tag widths;
  - NOP word constant 32'h0.
- Sub-module icache_line_store holds the valid/tag/data arrays: combinational read port (index, offset), write port for one data word, and a tag/valid install strobe.
- The FSM, PC, and memory handshake stay in icache_fetch.

Test Plan:
- Cold start: reset, release; mem_ready=1 every cycle, mem_data=addr → mem_addr sequence 0,4,8,12. First hit_out=1 at cycle 6 with instruction_out=0, next_pc_out=4. Next three cycles hit with 4, 8, 12.
- Stalled memory: mem_ready=0 for 5 cycles, then beats → mem_addr stays 0x0 and mem_req stays 1 throughout; hit_out=0 until INSTALL+1.
- Redirect on hit: line 0 warm, branch_taken with target 0x8 at pc=0x0 → pc_out=0x8 next cycle, hit_out=1, instruction_out = word at 0x8.
- Redirect during refill: miss at 0x100, branch_taken target 0x4 mid-REFILL → line 0x100 installed (a later fetch of 0x100 hits), then pc=0x4.
- Conflict eviction: fill 0x000, then fetch 0x100 (same index 0) → miss and refill; re-fetching 0x000 misses again.
- Async reset mid-refill: assert reset on beat 2 → mem_req=0 immediately, pc=RESET_PC, valid cleared, next fetch of that line misses. With ICACHE_STATS_EN: counters read 0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and helpers for the instruction-fetch stage and its direct-mapped cache.
// Holds the fetch FSM state enum, instruction width, the NOP word and the address-split width helpers.
// Build option: ICACHE_STATS_EN (used by icache_fetch) adds hit/miss counters.
package icache_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    LOOKUP  = 2'd0,
    REFILL  = 2'd1,
    INSTALL = 2'd2
  } fetchState_e;

  // Word-offset field width: log2(words per line).
  function automatic int unsigned offWidth(input int unsigned wordsPerLine);
    return $clog2(wordsPerLine);
  endfunction

  // Line-index field width: log2(lines).
  function automatic int unsigned idxWidth(input int unsigned lines);
    return $clog2(lines);
  endfunction

  // Tag width: everything above index, offset and the two byte bits.
  function automatic int unsigned tagWidth(input int unsigned lines, input int unsigned wordsPerLine);
    return INSTR_W - offWidth(wordsPerLine) - idxWidth(lines) - 2;
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the direct-mapped instruction cache.
// Ports:
//   clock, reset        - clock; async active-high reset clears every valid bit
//   lineIndex           - line selected for read, word write and install
//   readOffset          - word within the line for the combinational read
//   readValid/readTag   - valid bit and stored tag of lineIndex
//   readWord            - data word at [lineIndex][readOffset]
//   writeEn/Offset/Data - write one refill word into lineIndex
//   installEn/installTag- mark lineIndex valid with the given tag
module icache_line_store
  import icache_pkg::*;
#(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned TAG_W          = tagWidth(LINES, WORDS_PER_LINE)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [idxWidth(LINES)-1:0]           lineIndex,
  input  logic [offWidth(WORDS_PER_LINE)-1:0]  readOffset,
  output logic                                 readValid,
  output logic [TAG_W-1:0]                     readTag,
  output logic [INSTR_W-1:0]                   readWord,
  input  logic                                 writeEn,
  input  logic [offWidth(WORDS_PER_LINE)-1:0]  writeOffset,
  input  logic [INSTR_W-1:0]                   writeData,
  input  logic                                 installEn,
  input  logic [TAG_W-1:0]                     installTag
);

  logic [LINES-1:0]   validBits;
  logic [TAG_W-1:0]   tagMem  [LINES];
  logic [INSTR_W-1:0] dataMem [LINES][WORDS_PER_LINE];

  // Valid bits are the only state that must reset; tag/data are qualified by them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      validBits <= '0;
    end else if (installEn) begin
      validBits[lineIndex] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (installEn) begin
      tagMem[lineIndex] <= installTag;
    end
    if (writeEn) begin
      dataMem[lineIndex][writeOffset] <= writeData;
    end
  end

  assign readValid = validBits[lineIndex];
  assign readTag   = tagMem[lineIndex];
  assign readWord  = dataMem[lineIndex][readOffset];

endmodule

// File: rtl/icache_fetch.sv
// Instruction-fetch stage: owns the PC, looks it up in a direct-mapped cache and
// refills a missing line from instruction memory before replaying the lookup.
// Ports:
//   clock, reset                 - clock; async active-high reset
//   branch_taken, branch_target  - redirect request from a later stage
//   instruction_out, hit_out     - IF/ID payload; downstream captures only when hit_out=1
//   next_pc_out, pc_out          - PC + 4 and current PC
//   mem_req, mem_addr            - refill read request and word address
//   mem_ready, mem_data          - one refill word per ready beat
//   hit_count, miss_count        - only when ICACHE_STATS_EN is defined
module icache_fetch
  import icache_pkg::*;
#(
  parameter int unsigned         LINES          = 16,
  parameter int unsigned         WORDS_PER_LINE = 4,
  parameter logic [INSTR_W-1:0]  RESET_PC       = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               branch_taken,
  input  logic [INSTR_W-1:0] branch_target,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [INSTR_W-1:0] next_pc_out,
  output logic               hit_out,
  output logic [INSTR_W-1:0] pc_out,
  output logic               mem_req,
  output logic [INSTR_W-1:0] mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);

  localparam int unsigned OFF_W = offWidth(WORDS_PER_LINE);
  localparam int unsigned IDX_W = idxWidth(LINES);
  localparam int unsigned TAG_W = tagWidth(LINES, WORDS_PER_LINE);
  localparam logic [INSTR_W-1:0] LINE_MASK = INSTR_W'(WORDS_PER_LINE * 4 - 1);
  localparam logic [OFF_W-1:0]   LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  fetchState_e        state, stateNext;
  logic [INSTR_W-1:0] pc, pcNext;
  logic               memReq, memReqNext;
  logic [INSTR_W-1:0] memAddr, memAddrNext;
  logic [OFF_W-1:0]   beatCnt, beatCntNext;
  logic               redirectPending, redirectPendingNext;
  logic [INSTR_W-1:0] pendingTarget, pendingTargetNext;

  logic [OFF_W-1:0]   pcOffset;
  logic [IDX_W-1:0]   pcIndex;
  logic [TAG_W-1:0]   pcTag;
  logic [INSTR_W-1:0] targetAligned;
  logic               lineValid;
  logic [TAG_W-1:0]   lineTag;
  logic [INSTR_W-1:0] lineWord;
  logic               hitC;
  logic               writeEn;
  logic               installEn;

  assign pcOffset      = pc[OFF_W+1:2];
  assign pcIndex       = pc[OFF_W+IDX_W+1:OFF_W+2];
  assign pcTag         = pc[INSTR_W-1:OFF_W+IDX_W+2];
  assign targetAligned = branch_target & ~INSTR_W'(3);

  // PC stays put through REFILL/INSTALL, so one index serves read, refill and install.
  icache_line_store #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_W          (TAG_W)
  ) lineStore (
    .clock       (clock),
    .reset       (reset),
    .lineIndex   (pcIndex),
    .readOffset  (pcOffset),
    .readValid   (lineValid),
    .readTag     (lineTag),
    .readWord    (lineWord),
    .writeEn     (writeEn),
    .writeOffset (beatCnt),
    .writeData   (mem_data),
    .installEn   (installEn),
    .installTag  (pcTag)
  );

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= LOOKUP;
      pc              <= RESET_PC;
      memReq          <= 1'b0;
      memAddr         <= '0;
      beatCnt         <= '0;
      redirectPending <= 1'b0;
      pendingTarget   <= '0;
    end else begin
      state           <= stateNext;
      pc              <= pcNext;
      memReq          <= memReqNext;
      memAddr         <= memAddrNext;
      beatCnt         <= beatCntNext;
      redirectPending <= redirectPendingNext;
      pendingTarget   <= pendingTargetNext;
    end
  end

  // Next-state, PC and refill handshake.
  always_comb begin
    stateNext           = state;
    pcNext              = pc;
    memReqNext          = memReq;
    memAddrNext         = memAddr;
    beatCntNext         = beatCnt;
    redirectPendingNext = redirectPending;
    pendingTargetNext   = pendingTarget;
    hitC                = 1'b0;
    writeEn             = 1'b0;
    installEn           = 1'b0;

    case (state)
      LOOKUP: begin
        hitC = lineValid && (lineTag == pcTag);
        if (hitC) begin
          pcNext = branch_taken ? targetAligned : pc + 32'd4;
        end else if (branch_taken) begin
          // Missed fetch is on the wrong path anyway: skip the refill.
          pcNext = targetAligned;
        end else begin
          stateNext   = REFILL;
          memReqNext  = 1'b1;
          memAddrNext = pc & ~LINE_MASK;
          beatCntNext = '0;
        end
      end

      REFILL: begin
        if (memReq && mem_ready) begin
          writeEn     = 1'b1;
          beatCntNext = beatCnt + OFF_W'(1);
          memAddrNext = memAddr + 32'd4;
          if (beatCnt == LAST_BEAT) begin
            memReqNext = 1'b0;
            stateNext  = INSTALL;
          end
        end
        if (branch_taken) begin
          redirectPendingNext = 1'b1;
          pendingTargetNext   = targetAligned;
        end
      end

      INSTALL: begin
        installEn           = 1'b1;
        stateNext           = LOOKUP;
        redirectPendingNext = 1'b0;
        // A redirect arriving this very cycle is newer than any pending one.
        if (branch_taken) begin
          pcNext = targetAligned;
        end else if (redirectPending) begin
          pcNext = pendingTarget;
        end
      end

      default: begin
        stateNext = LOOKUP;
      end
    endcase
  end

  assign hit_out         = hitC;
  assign instruction_out = hitC ? lineWord : NOP_WORD;
  assign pc_out          = pc;
  assign next_pc_out     = pc + 32'd4;
  assign mem_req         = memReq;
  assign mem_addr        = memAddr;

`ifdef ICACHE_STATS_EN
  logic lookupMiss;
  assign lookupMiss = (state == LOOKUP) && !hitC && !branch_taken;

  // Performance counters; wrap naturally at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hitC) begin
        hit_count <= hit_count + 32'd1;
      end
      if (lookupMiss) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: cold-start vector table, then hand-written
// sequences for stalled refill, redirects, conflict eviction, reset mid-refill
// and PC wrap-around. Memory returns each word equal to its own address.
module tb_icache_fetch;

  logic        clock;
  logic        reset;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic [31:0] instruction;
  logic [31:0] nextPc;
  logic        hit;
  logic [31:0] pc;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memReady;
  logic [31:0] memData;
`ifdef ICACHE_STATS_EN
  logic [31:0] hitCount;
  logic [31:0] missCount;
`endif

  icache_fetch dut (
    .clock           (clock),
    .reset           (reset),
    .branch_taken    (branchTaken),
    .branch_target   (branchTarget),
    .instruction_out (instruction),
    .next_pc_out     (nextPc),
    .hit_out         (hit),
    .pc_out          (pc),
    .mem_req         (memReq),
    .mem_addr        (memAddr),
    .mem_ready       (memReady),
    .mem_data        (memData)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count       (hitCount),
    .miss_count      (missCount)
`endif
  );

  assign memData = memAddr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic waitHit(input string name, input int maxCycles, input int expCycles);
    int n;
    n = 0;
    while (!hit && n < maxCycles) begin
      cycle();
      n++;
    end
    check(name, 32'(n), 32'(expCycles));
  endtask

  task automatic redirect(input logic [31:0] target);
    branchTaken  = 1'b1;
    branchTarget = target;
    cycle();
    branchTaken  = 1'b0;
    branchTarget = 32'h0;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        expHit;
    logic [31:0] expPc;
    logic [31:0] expInstr;
    logic        expReq;
    logic [31:0] expAddr;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic br, input logic [31:0] tgt, input logic rdy,
                              input logic h, input logic [31:0] p, input logic [31:0] ins,
                              input logic rq, input logic [31:0] ad);
    vec_t v;
    v.br = br; v.tgt = tgt; v.rdy = rdy;
    v.expHit = h; v.expPc = p; v.expInstr = ins; v.expReq = rq; v.expAddr = ad;
    return v;
  endfunction

  initial begin
    // Cold start: miss at 0, four beats, install, then hits plus two redirects.
    vecs[0]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    vecs[1]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    vecs[2]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h4);
    vecs[3]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8);
    vecs[4]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'hC);
    vecs[5]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h10);
    vecs[6]  = mk(1'b1, 32'h8, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 32'h10);
    vecs[7]  = mk(1'b1, 32'h6, 1'b1, 1'b1, 32'h8, 32'h8, 1'b0, 32'h10);
    vecs[8]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 32'h4, 1'b0, 32'h10);
    vecs[9]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 32'h8, 1'b0, 32'h10);
    vecs[10] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 32'hC, 1'b0, 32'h10);

    reset        = 1'b1;
    branchTaken  = 1'b0;
    branchTarget = 32'h0;
    memReady     = 1'b0;

    @(negedge clock);
    check("reset hit", 32'(hit), 32'h0);
    check("reset pc", pc, 32'h0);
    check("reset next_pc", nextPc, 32'h4);
    check("reset instr", instruction, 32'h0);
    check("reset mem_req", 32'(memReq), 32'h0);
    check("reset mem_addr", memAddr, 32'h0);
`ifdef ICACHE_STATS_EN
    check("reset hit_count", hitCount, 32'h0);
    check("reset miss_count", missCount, 32'h0);
`endif
    @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      branchTaken  = vecs[i].br;
      branchTarget = vecs[i].tgt;
      memReady     = vecs[i].rdy;
      @(negedge clock);
      check($sformatf("vec%0d hit", i), 32'(hit), 32'(vecs[i].expHit));
      check($sformatf("vec%0d pc", i), pc, vecs[i].expPc);
      check($sformatf("vec%0d next_pc", i), nextPc, vecs[i].expPc + 32'd4);
      check($sformatf("vec%0d instr", i), instruction, vecs[i].expInstr);
      check($sformatf("vec%0d mem_req", i), 32'(memReq), 32'(vecs[i].expReq));
      check($sformatf("vec%0d mem_addr", i), memAddr, vecs[i].expAddr);
      @(posedge clock);
      #1;
    end
    branchTaken = 1'b0;

    // Stalled memory: request and address hold while mem_ready stays low.
    memReady = 1'b0;
    applyReset();
    check("stall miss", 32'(hit), 32'h0);
    cycle();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d req", i), 32'(memReq), 32'h1);
      check($sformatf("stall%0d addr", i), memAddr, 32'h0);
      check($sformatf("stall%0d hit", i), 32'(hit), 32'h0);
      cycle();
    end
    memReady = 1'b1;
    waitHit("stall latency", 20, 5);
    check("stall instr", instruction, 32'h0);
    check("stall pc", pc, 32'h0);
`ifdef ICACHE_STATS_EN
    check("stall miss_count", missCount, 32'h1);
    check("stall hit_count", hitCount, 32'h0);
`endif

    // Conflict eviction and redirect during refill.
    redirect(32'h100);
    check("conf pc", pc, 32'h100);
    check("conf miss", 32'(hit), 32'h0);
    cycle();
    check("conf req", 32'(memReq), 32'h1);
    check("conf addr", memAddr, 32'h100);
    cycle();
    check("conf beat1 addr", memAddr, 32'h104);
    redirect(32'h4);
    check("rir pc held", pc, 32'h100);
    check("rir addr", memAddr, 32'h108);
    cycle();
    check("rir last addr", memAddr, 32'h10C);
    cycle();
    check("rir install req", 32'(memReq), 32'h0);
    check("rir install hit", 32'(hit), 32'h0);
    check("rir install pc", pc, 32'h100);
    cycle();
    check("rir pending pc", pc, 32'h4);
    check("evicted 0 miss", 32'(hit), 32'h0);
    redirect(32'h100);
    check("0x100 pc", pc, 32'h100);
    check("0x100 hit", 32'(hit), 32'h1);
    check("0x100 instr", instruction, 32'h100);
    check("0x100 no refill", 32'(memReq), 32'h0);
    redirect(32'h0);
    check("refetch 0 pc", pc, 32'h0);
    check("refetch 0 miss", 32'(hit), 32'h0);
    cycle();
    check("refetch 0 req", 32'(memReq), 32'h1);
    check("refetch 0 addr", memAddr, 32'h0);

    // Async reset on beat 2 of a refill.
    cycle();
    cycle();
    check("pre-reset addr", memAddr, 32'h8);
    #2 reset = 1'b1;
    #1;
    check("async req drop", 32'(memReq), 32'h0);
    check("async pc", pc, 32'h0);
    check("async hit", 32'(hit), 32'h0);
`ifdef ICACHE_STATS_EN
    check("async hit_count", hitCount, 32'h0);
    check("async miss_count", missCount, 32'h0);
`endif
    @(posedge clock);
    #1 reset = 1'b0;
    check("post-reset miss", 32'(hit), 32'h0);
    cycle();
    check("post-reset req", 32'(memReq), 32'h1);
    check("post-reset addr", memAddr, 32'h0);
    waitHit("post-reset refill", 20, 5);

    // PC wrap-around at the top of the address space.
    redirect(32'hFFFF_FFFC);
    check("wrap pc", pc, 32'hFFFF_FFFC);
    check("wrap miss", 32'(hit), 32'h0);
    cycle();
    check("wrap base addr", memAddr, 32'hFFFF_FFF0);
    waitHit("wrap refill", 20, 5);
    check("wrap instr", instruction, 32'hFFFF_FFFC);
    check("wrap next_pc", nextPc, 32'h0);
    cycle();
    check("wrapped pc", pc, 32'h0);
    check("wrapped hit", 32'(hit), 32'h1);
    check("wrapped instr", instruction, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
